// File: rtl/golay_pkg.sv
// Shared constants, types and the Golay(23,12) parity function.
// Purely combinational helpers; no state lives here.
// Used by the lane encoder and the multi-lane top.
package golay_pkg;

  localparam int          C_K      = 12;
  localparam logic [11:0] C_POLY   = 12'hC75;
  localparam int          C_CW_MAX = 24;

  // One lane codeword at its widest (extended) size.
  typedef logic [C_CW_MAX-1:0] lane_cw_t;

  // Lane codeword width: 24 for extended, 23 for the perfect code.
  function automatic int cw_width(input int extended);
    return (extended != 0) ? 24 : 23;
  endfunction

  // data * x^11 mod g(x), shifted in MSB first through an 11-stage divider.
  function automatic logic [10:0] golay_parity(input logic [C_K-1:0] data);
    logic [10:0] rem;
    logic        fb;
    rem = '0;
    for (int i = C_K - 1; i >= 0; i--) begin
      fb  = data[i] ^ rem[10];
      rem = {rem[9:0], 1'b0};
      if (fb) rem = rem ^ C_POLY[10:0];
    end
    return rem;
  endfunction

endpackage

// File: rtl/golay_lane_enc.sv
// Single-lane systematic Golay encoder: {data, parity[, even-weight bit]}.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when the result is captured.
module golay_lane_enc
  import golay_pkg::*;
#(
  parameter int G_EXTENDED = 1
) (
  input  logic [C_K-1:0]                    data,
  output logic [cw_width(G_EXTENDED)-1:0]   code
);

  localparam int CW = cw_width(G_EXTENDED);

  logic [22:0] base;
  lane_cw_t    full;

  assign base = {data, golay_parity(data)};

  // The overall parity bit appended last makes the 24-bit word even weight.
  if (G_EXTENDED != 0) begin : g_ext
    assign full = {base, ^base};
  end else begin : g_std
    assign full = {1'b0, base};
  end

  assign code = full[CW-1:0];

endmodule

// File: rtl/golay_multi_encoder.sv
// Encodes G_LANES 12-bit lanes per strobe into a first-word-fall-through FIFO.
// Latency: accepted word is visible on valid_o the cycle after the accept edge.
// Backpressure: rdy_o = not full (never looks at ack_i); strobes while full are dropped and flagged.
module golay_multi_encoder
  import golay_pkg::*;
#(
  parameter int G_LANES    = 4,
  parameter int G_EXTENDED = 1,
  parameter int G_DEPTH    = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               stb_i,
  input  logic [12*G_LANES-1:0]              payload_i,
  input  logic                               interleave_i,
  output logic                               rdy_o,
  output logic                               valid_o,
  output logic [(23+G_EXTENDED)*G_LANES-1:0] code_word_o,
  input  logic                               ack_i,
  output logic [15:0]                        words_o,
  output logic                               drop_o
);

  localparam int CW = cw_width(G_EXTENDED);
  localparam int W  = CW * G_LANES;
  localparam int AW = (G_DEPTH > 1) ? $clog2(G_DEPTH) : 1;

  logic [W-1:0]       enc_word;
  logic [W-1:0]       mem_cw [G_DEPTH];
  logic [G_DEPTH-1:0] mem_il;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count;
  logic               full;
  logic               push;
  logic               pop;
  logic [W-1:0]       head;
  logic [W-1:0]       head_il;

  for (genvar l = 0; l < G_LANES; l++) begin : g_lane
    golay_lane_enc #(.G_EXTENDED(G_EXTENDED)) u_enc (
      .data (payload_i[12*l +: 12]),
      .code (enc_word[CW*l +: CW])
    );
  end

  // rdy_o is held low during reset so a strobe in a reset cycle is never taken.
  assign full    = (count == (AW+1)'(G_DEPTH));
  assign rdy_o   = !full && !rst_i;
  assign valid_o = (count != '0);
  assign push    = stb_i && rdy_o;
  assign pop     = valid_o && ack_i;
  assign head    = mem_cw[rd_ptr];

  // Bit k of lane l moves to bit k*G_LANES+l so lanes alternate bit by bit.
  always_comb begin
    head_il = '0;
    for (int l = 0; l < G_LANES; l++) begin
      for (int k = 0; k < CW; k++) begin
        head_il[k*G_LANES + l] = head[CW*l + k];
      end
    end
  end

  assign code_word_o = !valid_o         ? '0      :
                       mem_il[rd_ptr]   ? head_il : head;

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_cw[wr_ptr] <= enc_word;
      mem_il[wr_ptr] <= interleave_i;
    end
  end

  // Pointers, occupancy, delivered-word counter and the sticky drop flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      words_o <= '0;
      drop_o  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        words_o <= words_o + 16'd1;
      end
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (!push && pop) count <= count - (AW+1)'(1);
      if (stb_i && !rdy_o) drop_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_golay_multi_encoder.sv
// Directed bench for golay_multi_encoder: defaults, 23-bit single lane, two-lane interleave.
// Inputs change 1ns after a rising edge; outputs are read at that point too.
// Expected codewords are hand-computed constants plus an independent long-division model.
module tb_golay_multi_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Default instance: 4 lanes, extended, depth 4.
  logic        rst = 1'b1, stb = 1'b0, il = 1'b0, ack = 1'b0;
  logic [47:0] payload = '0;
  logic        rdy, vld, drop;
  logic [95:0] code;
  logic [15:0] words;

  golay_multi_encoder dut (
    .clk_i(clk), .rst_i(rst), .stb_i(stb), .payload_i(payload),
    .interleave_i(il), .rdy_o(rdy), .valid_o(vld), .code_word_o(code),
    .ack_i(ack), .words_o(words), .drop_o(drop)
  );

  // Single-lane 23-bit instance.
  logic        rst_n = 1'b1, stb_n = 1'b0, ack_n = 1'b0;
  logic [11:0] payload_n = '0;
  logic        rdy_n, vld_n, drop_n;
  logic [22:0] code_n;
  logic [15:0] words_n;

  golay_multi_encoder #(.G_LANES(1), .G_EXTENDED(0), .G_DEPTH(2)) dut_n (
    .clk_i(clk), .rst_i(rst_n), .stb_i(stb_n), .payload_i(payload_n),
    .interleave_i(1'b0), .rdy_o(rdy_n), .valid_o(vld_n), .code_word_o(code_n),
    .ack_i(ack_n), .words_o(words_n), .drop_o(drop_n)
  );

  // Two-lane extended instance for the interleave layout.
  logic        rst_i2 = 1'b1, stb_i2 = 1'b0, il_i2 = 1'b0, ack_i2 = 1'b0;
  logic [23:0] payload_i2 = '0;
  logic        rdy_i2, vld_i2, drop_i2;
  logic [47:0] code_i2;
  logic [15:0] words_i2;

  golay_multi_encoder #(.G_LANES(2), .G_EXTENDED(1), .G_DEPTH(4)) dut_i (
    .clk_i(clk), .rst_i(rst_i2), .stb_i(stb_i2), .payload_i(payload_i2),
    .interleave_i(il_i2), .rdy_o(rdy_i2), .valid_o(vld_i2), .code_word_o(code_i2),
    .ack_i(ack_i2), .words_o(words_i2), .drop_o(drop_i2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: full polynomial long division of d*x^11 by 0xC75, then even-weight bit.
  function automatic logic [23:0] enc_model(input logic [11:0] d);
    logic [22:0] v;
    logic [22:0] cw;
    v = {d, 11'b0};
    for (int i = 22; i >= 11; i--) begin
      if (v[i]) v = v ^ (23'(12'hC75) << (i - 11));
    end
    cw = {d, v[10:0]};
    return {cw, ^cw};
  endfunction

  task automatic do_reset();
    rst = 1'b1; stb = 1'b0; ack = 1'b0; il = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stb = 1'b1;
    step();
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy_low: got %b want 0", rdy); end
    total++; if (vld !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", vld); end
    total++; if (code !== 96'h0) begin bad++; $display("FAIL reset_code: got %h want 0", code); end
    total++; if (words !== 16'h0) begin bad++; $display("FAIL reset_words: got %h want 0", words); end
    total++; if (drop !== 1'b0) begin bad++; $display("FAIL reset_drop: got %b want 0", drop); end
    rst = 1'b0; stb = 1'b0;
    #1;
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy_high: got %b want 1", rdy); end
    step();
    total++; if (vld !== 1'b0) begin bad++; $display("FAIL reset_no_accept: got %b want 0", vld); end
  endtask

  task automatic test_lane_encode();
    logic [23:0] m;
    payload = {12'h800, 12'h001, 12'hFFF, 12'h000};
    stb = 1'b1; ack = 1'b1; il = 1'b0;
    #1;
    total++; if (vld !== 1'b0) begin bad++; $display("FAIL enc_valid_before: got %b want 0", vld); end
    step();
    stb = 1'b0;
    total++; if (vld !== 1'b1) begin bad++; $display("FAIL enc_valid_after: got %b want 1", vld); end
    total++; if (code !== 96'h800C75_0018EB_FFFFFF_000000) begin
      bad++; $display("FAIL enc_word: got %h want 800c750018ebffffff000000", code);
    end
    m = enc_model(12'h800);
    total++; if (code[95:72] !== m) begin bad++; $display("FAIL enc_lane3_model: got %h want %h", code[95:72], m); end
    step();
    total++; if (vld !== 1'b0 || code !== 96'h0) begin
      bad++; $display("FAIL enc_popped: got valid=%b code=%h want valid=0 code=0", vld, code);
    end
    total++; if (words !== 16'd1) begin bad++; $display("FAIL enc_words: got %0d want 1", words); end
    ack = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [11:0] vals [5];
    logic [23:0] exps [4];
    vals = '{12'h001, 12'h800, 12'hFFF, 12'h000, 12'h001};
    exps = '{24'h0018EB, 24'h800C75, 24'hFFFFFF, 24'h000000};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      payload = {4{vals[i]}}; stb = 1'b1;
      step();
      if (i == 3) begin
        total++; if (rdy !== 1'b0) begin bad++; $display("FAIL bp_rdy_full: got %b want 0", rdy); end
      end
    end
    stb = 1'b0;
    total++; if (drop !== 1'b1) begin bad++; $display("FAIL bp_drop: got %b want 1", drop); end
    total++; if (words !== 16'd0) begin bad++; $display("FAIL bp_words0: got %0d want 0", words); end
    ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (vld !== 1'b1 || code !== {4{exps[i]}}) begin
        bad++; $display("FAIL bp_order%0d: got valid=%b code=%h want valid=1 code=%h", i, vld, code, {4{exps[i]}});
      end
      step();
    end
    total++; if (vld !== 1'b0) begin bad++; $display("FAIL bp_drained: got %b want 0", vld); end
    total++; if (words !== 16'd4) begin bad++; $display("FAIL bp_words4: got %0d want 4", words); end
    ack = 1'b0;
  endtask

  task automatic test_full_ack_and_reset();
    do_reset();
    payload = {4{12'h001}}; stb = 1'b1;
    repeat (4) step();
    payload = {4{12'hFFF}}; ack = 1'b1;
    step();
    stb = 1'b0; ack = 1'b0;
    total++; if (drop !== 1'b1) begin bad++; $display("FAIL full_ack_drop: got %b want 1", drop); end
    total++; if (words !== 16'd1) begin bad++; $display("FAIL full_ack_words: got %0d want 1", words); end
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL full_ack_rdy: got %b want 1", rdy); end
    total++; if (code !== {4{24'h0018EB}}) begin bad++; $display("FAIL full_ack_head: got %h want %h", code, {4{24'h0018EB}}); end
    rst = 1'b1; stb = 1'b1;
    step();
    total++; if (vld !== 1'b0 || words !== 16'd0 || drop !== 1'b0) begin
      bad++; $display("FAIL midreset: got valid=%b words=%0d drop=%b want 0 0 0", vld, words, drop);
    end
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL midreset_rdy: got %b want 0", rdy); end
    rst = 1'b0; stb = 1'b0;
    #1;
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL midreset_rdy_after: got %b want 1", rdy); end
    step();
    total++; if (vld !== 1'b0) begin bad++; $display("FAIL midreset_empty: got %b want 0", vld); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    payload = '0; stb = 1'b1; ack = 1'b1;
    step();
    repeat (65535) step();
    total++; if (words !== 16'hFFFF) begin bad++; $display("FAIL wrap_ffff: got %h want ffff", words); end
    step();
    total++; if (words !== 16'h0000) begin bad++; $display("FAIL wrap_zero: got %h want 0000", words); end
    stb = 1'b0; ack = 1'b0;
  endtask

  task automatic test_no_extended();
    rst_n = 1'b1; step(); rst_n = 1'b0;
    payload_n = 12'h001; stb_n = 1'b1;
    step();
    stb_n = 1'b0;
    total++; if (code_n !== 23'h000C75) begin bad++; $display("FAIL std_001: got %h want 000c75", code_n); end
    total++; if (code_n[22:11] !== 12'h001) begin bad++; $display("FAIL std_upper: got %h want 001", code_n[22:11]); end
    ack_n = 1'b1;
    step();
    ack_n = 1'b0; payload_n = 12'h800; stb_n = 1'b1;
    step();
    stb_n = 1'b0;
    total++; if (code_n !== 23'h40063A) begin bad++; $display("FAIL std_800: got %h want 40063a", code_n); end
  endtask

  task automatic test_interleave();
    rst_i2 = 1'b1; step(); rst_i2 = 1'b0;
    payload_i2 = {12'h000, 12'h001}; il_i2 = 1'b1; stb_i2 = 1'b1;
    step();
    il_i2 = 1'b0;
    step();
    stb_i2 = 1'b0;
    total++; if (code_i2 !== 48'h000001405445) begin bad++; $display("FAIL il_on: got %h want 000001405445", code_i2); end
    ack_i2 = 1'b1;
    step();
    ack_i2 = 1'b0;
    total++; if (code_i2 !== 48'h0000000018EB) begin bad++; $display("FAIL il_off: got %h want 0000000018eb", code_i2); end
  endtask

  initial begin
    test_reset();
    test_lane_encode();
    test_backpressure();
    test_full_ack_and_reset();
    test_no_extended();
    test_interleave();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
